// File: rtl/conv_pkg.sv
// Shared types and helpers for the tile convolution engine: FSM encoding,
// output-size arithmetic and output saturation.
package conv_pkg;

    localparam int SHIFT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH1,
        ST_FLUSH2,
        ST_EMIT,
        ST_DONE
    } conv_state_t;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } sat_result_t;

    function automatic int out_dim(input int tile, input int k, input int stride);
        return (tile - k) / stride + 1;
    endfunction

    // Clamp to the signed range of an out_w-bit word; sat flags a clamp.
    function automatic sat_result_t sat_clamp(input logic signed [63:0] value, input int out_w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sat_result_t        res;
        max_v   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (out_w - 1));
        res.sat = 1'b1;
        if (value > max_v) begin
            res.value = max_v;
        end else if (value < min_v) begin
            res.value = min_v;
        end else begin
            res.value = value;
            res.sat   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/conv2d_tile_engine_if.sv
// Output pixel stream of the tile convolution engine (valid/ready).
interface conv2d_tile_engine_if #(
    parameter int OUT_W   = 16,
    parameter int COORD_W = 3
);
    logic                      out_valid;
    logic                      out_ready;
    logic signed [OUT_W-1:0]   out_data;
    logic        [COORD_W-1:0] out_row;
    logic        [COORD_W-1:0] out_col;
    logic                      out_last;

    modport master (output out_valid, out_data, out_row, out_col, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_row, out_col, out_last, output out_ready);
endinterface

// File: rtl/conv_row_mac.sv
// One kernel row of multiply-accumulate: K registered signed products and a
// combinational sum of them, sign-extended to the accumulator width.
module conv_row_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int K      = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [0:K-1][DATA_W-1:0]      a,
    input  logic [0:K-1][DATA_W-1:0]      b,
    output logic signed [ACC_W-1:0]       row_sum
);
    localparam int KIDX_W = (K > 1) ? $clog2(K) : 1;

    logic signed [2*DATA_W-1:0] prod_q [K];

    // NOTE: product registers are reset so nothing stale can reach the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) prod_q[i] <= '0;
        end else begin
            for (int i = 0; i < K; i++)
                prod_q[i] <= $signed(a[KIDX_W'(i)]) * $signed(b[KIDX_W'(i)]);
        end
    end

    // NOTE: blocking assignments are correct here: this is pure combinational summing.
    always_comb begin
        row_sum = '0;
        for (int i = 0; i < K; i++) row_sum = row_sum + ACC_W'(prod_q[KIDX_W'(i)]);
    end

endmodule

// File: rtl/conv2d_tile_engine.sv
// Parametrised 2-D convolution over a captured tile: one kernel row per cycle,
// then bias, requantisation shift, optional ReLU and saturation per output pixel.
module conv2d_tile_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int K      = 3,
    parameter int TILE   = 6,
    parameter int STRIDE = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [0:TILE-1][0:TILE-1][DATA_W-1:0] tile_in,
    input  logic [0:K-1][0:K-1][DATA_W-1:0]       kernel_in,
    input  logic signed [ACC_W-1:0]               bias_in,
    input  logic [SHIFT_W-1:0]                    shift_in,
    input  logic                                  relu_en,
    conv2d_tile_engine_if.master                  out_if,
    output logic                                  busy,
    output logic                                  done,
    output logic [15:0]                           sat_count
);
    localparam int OUT_DIM = out_dim(TILE, K, STRIDE);
    localparam int COORD_W = $clog2(OUT_DIM) + 1;
    localparam int KIDX_W  = (K > 1) ? $clog2(K) : 1;
    localparam int TIDX_W  = (TILE > 1) ? $clog2(TILE) : 1;

    if (TILE < K || STRIDE < 1 || ((TILE - K) % STRIDE) != 0) begin : g_bad_cfg
        $error("conv2d_tile_engine: TILE/K/STRIDE do not tile evenly");
    end

    conv_state_t state, state_nxt;

    logic [0:TILE-1][0:TILE-1][DATA_W-1:0] tile_q;
    logic [0:K-1][0:K-1][DATA_W-1:0]       kernel_q;
    logic signed [ACC_W-1:0]               bias_q;
    logic [SHIFT_W-1:0]                    shift_q;
    logic                                  relu_q;

    logic [COORD_W-1:0]      r_q, c_q;
    logic [KIDX_W-1:0]       kr_q;
    logic signed [ACC_W-1:0] acc_q, row_sum, shifted, rectified;
    logic                    prod_valid_q, prod_first_q;
    logic [0:K-1][DATA_W-1:0] mac_a, mac_b;
    sat_result_t             clamp;
    logic                    clamp_unused;
    logic                    start_job, emit_hs, last_pix, row_end;

    assign start_job = (state == ST_IDLE) && start && !abort;
    assign last_pix  = (r_q == COORD_W'(OUT_DIM - 1)) && (c_q == COORD_W'(OUT_DIM - 1));
    assign emit_hs   = (state == ST_EMIT) && out_if.out_ready && !abort;
    assign row_end   = (kr_q == KIDX_W'(K - 1));

    assign busy             = (state != ST_IDLE);
    assign done             = (state == ST_DONE);
    assign out_if.out_valid = (state == ST_EMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_RUN;
            ST_RUN:    if (row_end) state_nxt = ST_FLUSH1;
            ST_FLUSH1: state_nxt = ST_FLUSH2;
            ST_FLUSH2: state_nxt = ST_EMIT;
            ST_EMIT:   if (out_if.out_ready) state_nxt = last_pix ? ST_DONE : ST_RUN;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

    // Window row kr of pixel (r,c) feeds the row MAC.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        for (int j = 0; j < K; j++) begin
            mac_a[KIDX_W'(j)] = tile_q[TIDX_W'(r_q * STRIDE + kr_q)][TIDX_W'(c_q * STRIDE + j)];
            mac_b[KIDX_W'(j)] = kernel_q[kr_q][KIDX_W'(j)];
        end
    end

    conv_row_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .K(K)) u_row_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (mac_a),
        .b       (mac_b),
        .row_sum (row_sum)
    );

    always_comb begin
        shifted   = acc_q >>> shift_q;
        rectified = (relu_q && shifted[ACC_W-1]) ? '0 : shifted;
        clamp     = sat_clamp(64'(rectified), OUT_W);
    end
    assign clamp_unused = ^clamp.value[63:OUT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_q          <= '0;
            kernel_q        <= '0;
            bias_q          <= '0;
            shift_q         <= '0;
            relu_q          <= 1'b0;
            r_q             <= '0;
            c_q             <= '0;
            kr_q            <= '0;
            acc_q           <= '0;
            prod_valid_q    <= 1'b0;
            prod_first_q    <= 1'b0;
            sat_count       <= '0;
            out_if.out_data <= '0;
            out_if.out_row  <= '0;
            out_if.out_col  <= '0;
            out_if.out_last <= 1'b0;
        end else begin
            prod_valid_q <= (state == ST_RUN) && !abort;
            prod_first_q <= (state == ST_RUN) && (kr_q == '0);

            if (start_job) begin
                tile_q    <= tile_in;
                kernel_q  <= kernel_in;
                bias_q    <= bias_in;
                shift_q   <= shift_in;
                relu_q    <= relu_en;
                sat_count <= '0;
                r_q       <= '0;
                c_q       <= '0;
                kr_q      <= '0;
            end

            if (state == ST_RUN) kr_q <= row_end ? '0 : kr_q + 1'b1;

            // Products land one cycle after their RUN row; the first row seeds with bias.
            if (prod_valid_q) acc_q <= (prod_first_q ? bias_q : acc_q) + row_sum;

            if (state == ST_FLUSH2) begin
                out_if.out_data <= clamp.value[OUT_W-1:0];
                out_if.out_row  <= r_q;
                out_if.out_col  <= c_q;
                out_if.out_last <= last_pix;
                if (clamp.sat && sat_count != 16'hFFFF) sat_count <= sat_count + 1'b1;
            end

            if (emit_hs && !last_pix) begin
                if (c_q == COORD_W'(OUT_DIM - 1)) begin
                    c_q <= '0;
                    r_q <= r_q + 1'b1;
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end
        end
    end

endmodule
